// File: rtl/io_pkg.sv
// Shared constants for the buffered I/O port bank.
// No logic, no latency.
// No backpressure; constants only.
package io_pkg;

  // Bit positions inside cpu_status
  localparam int STAT_OVF     = 3;
  localparam int STAT_TXFULL  = 2;
  localparam int STAT_RXEMPTY = 1;
  localparam int STAT_RXNE    = 0;

  // Default datapath word width
  localparam int DATA_W_DEF   = 16;

endpackage

// File: rtl/io_fifo.sv
// Single-clock circular FIFO, DEPTH entries, head exposed combinationally.
// Latency: a pushed word is visible at o_head from the next cycle (no bypass).
// Backpressure: push when full is refused unless a pop happens in the same cycle.
module io_fifo
  import io_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_dat,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // A full FIFO still takes a word when the head leaves in the same cycle;
  // the slot being written is the one being vacated.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// Bank of CHANNELS buffered I/O channels: per-channel TX and RX FIFOs, CPU decode, sticky overflow.
// Latency: CPU read data and status are registered (1 cycle); TX head is combinational from FIFO state.
// Backpressure: in_ready is derived from registered RX occupancy only; TX drops words when full.
module io_port_bank
  import io_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CH_W-1:0]            cpu_ch,
  input  logic                       cpu_wr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic                       cpu_rd,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_rvalid,
  input  logic                       cpu_stat_rd,
  output logic [3:0]                 cpu_status,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  input  logic [CHANNELS-1:0]        in_valid,
  output logic [CHANNELS-1:0]        in_ready,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  output logic [CHANNELS-1:0]        out_valid,
  input  logic [CHANNELS-1:0]        out_ready
);

  logic [CHANNELS-1:0] w_sel;
  logic [CHANNELS-1:0] w_tx_push;
  logic [CHANNELS-1:0] w_tx_pop;
  logic [CHANNELS-1:0] w_tx_full;
  logic [CHANNELS-1:0] w_tx_empty;
  logic [CHANNELS-1:0] w_rx_push;
  logic [CHANNELS-1:0] w_rx_pop;
  logic [CHANNELS-1:0] w_rx_full;
  logic [CHANNELS-1:0] w_rx_empty;
  logic [CHANNELS-1:0] w_ovf_set;
  logic [CHANNELS-1:0] w_ovf_clr;
  logic [DATA_W-1:0]   w_rx_head [CHANNELS];
  logic [DATA_W-1:0]   w_head_sel;
  logic [3:0]          w_stat_sel;

  logic [CHANNELS-1:0] r_ovf;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;
  logic [3:0]          r_status;

  // An out-of-range cpu_ch matches no channel, so every CPU action is a no-op
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign w_sel[i]     = (cpu_ch == CH_W'(i));
    assign w_tx_push[i] = cpu_wr & w_sel[i];
    assign w_tx_pop[i]  = out_valid[i] & out_ready[i];
    assign w_rx_push[i] = in_valid[i] & in_ready[i];
    assign w_rx_pop[i]  = cpu_rd & w_sel[i] & ~w_rx_empty[i];
    assign w_ovf_set[i] = w_tx_push[i] & w_tx_full[i] & ~w_tx_pop[i];
    assign w_ovf_clr[i] = cpu_stat_rd & w_sel[i];

    io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
      .clk        (clk),
      .rst_n      (reset),
      .i_push     (w_tx_push[i]),
      .i_push_dat (cpu_wdata),
      .i_pop      (w_tx_pop[i]),
      .o_head     (out_data[i*DATA_W +: DATA_W]),
      .o_full     (w_tx_full[i]),
      .o_empty    (w_tx_empty[i])
    );

    io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
      .clk        (clk),
      .rst_n      (reset),
      .i_push     (w_rx_push[i]),
      .i_push_dat (in_data[i*DATA_W +: DATA_W]),
      .i_pop      (w_rx_pop[i]),
      .o_head     (w_rx_head[i]),
      .o_full     (w_rx_full[i]),
      .o_empty    (w_rx_empty[i])
    );
  end

  assign out_valid = ~w_tx_empty;
  assign in_ready  = ~w_rx_full;

  // Select RX head and pre-update status of the addressed channel (zero if none)
  always_comb begin
    w_head_sel = '0;
    w_stat_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_sel[i]) begin
        w_head_sel               = w_rx_head[i];
        w_stat_sel[STAT_OVF]     = r_ovf[i];
        w_stat_sel[STAT_TXFULL]  = w_tx_full[i];
        w_stat_sel[STAT_RXEMPTY] = w_rx_empty[i];
        w_stat_sel[STAT_RXNE]    = ~w_rx_empty[i];
      end
    end
  end

  // Sticky overflow: a new overflow wins over a same-cycle status clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ovf <= '0;
    else        r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
  end

  // Registered CPU read data, read strobe and status snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_status <= 4'(1 << STAT_RXEMPTY);
    end else begin
      r_rvalid <= |w_rx_pop;
      if (|w_rx_pop)  r_rdata  <= w_head_sel;
      if (cpu_stat_rd) r_status <= w_stat_sel;
    end
  end

  assign cpu_rdata  = r_rdata;
  assign cpu_rvalid = r_rvalid;
  assign cpu_status = r_status;

endmodule

// File: tb/tb_io_port_bank.sv
module tb_io_port_bank;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int DP = 4;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [CW-1:0]    cpu_ch;
  logic             cpu_wr;
  logic [DW-1:0]    cpu_wdata;
  logic             cpu_rd;
  logic [DW-1:0]    cpu_rdata;
  logic             cpu_rvalid;
  logic             cpu_stat_rd;
  logic [3:0]       cpu_status;
  logic [NC*DW-1:0] in_data;
  logic [NC-1:0]    in_valid;
  logic [NC-1:0]    in_ready;
  logic [NC*DW-1:0] out_data;
  logic [NC-1:0]    out_valid;
  logic [NC-1:0]    out_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  io_port_bank #(.DATA_W(DW), .CHANNELS(NC), .DEPTH(DP)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_ch      (cpu_ch),
    .cpu_wr      (cpu_wr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rd      (cpu_rd),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_stat_rd (cpu_stat_rd),
    .cpu_status  (cpu_status),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_w [4];
    logic [15:0] q [$];
    logic [15:0] ew;
    logic        iv, rd, acc, pop;
    int          cnt, sent, got;

    reset = 1'b0; cpu_ch = '0; cpu_wr = 0; cpu_wdata = '0; cpu_rd = 0;
    cpu_stat_rd = 0; in_data = '0; in_valid = '0; out_ready = '0;
    ew = '0; cnt = 0; sent = 0; got = 0;

    // ---- reset values
    #12;
    chk("rst_out_valid", out_valid, 4'h0);
    chk("rst_in_ready",  in_ready,  4'hF);
    chk("rst_rvalid",    cpu_rvalid, 0);
    chk("rst_status",    cpu_status, 4'b0010);
    reset = 1'b1;

    // ---- buffer data on ch1, then reset mid-stream
    tick();
    cpu_ch = 1; cpu_wr = 1; cpu_wdata = 16'hAAAA;
    in_data[16 +: 16] = 16'h1234; in_valid = 4'b0010;
    tick();
    in_valid = '0; cpu_wdata = 16'hBBBB; cpu_rd = 1; cpu_stat_rd = 1;
    tick();
    chk("ch1_rvalid", cpu_rvalid, 1);
    chk("ch1_rdata",  cpu_rdata,  16'h1234);
    chk("ch1_status_rxne", cpu_status, 4'b0001);
    cpu_rd = 0; cpu_stat_rd = 0; cpu_wdata = 16'hCCCC;
    tick();
    cpu_wr = 0;
    chk("ch1_out_valid", out_valid, 4'b0010);
    chk("ch1_out_head",  out_data[16 +: 16], 16'hAAAA);
    chk("ch1_rvalid_drop", cpu_rvalid, 0);
    reset = 1'b0;
    #2;
    chk("midrst_out_valid", out_valid, 4'h0);
    chk("midrst_in_ready",  in_ready,  4'hF);
    chk("midrst_rdata",     cpu_rdata, 16'h0);
    chk("midrst_status",    cpu_status, 4'b0010);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    chk("postrst_out_valid", out_valid, 4'h0);
    chk("postrst_in_ready",  in_ready,  4'hF);
    cpu_stat_rd = 1;
    tick();
    cpu_stat_rd = 0;
    chk("postrst_status_ch1", cpu_status, 4'b0010);
    chk("postrst_rvalid", cpu_rvalid, 0);

    // ---- TX fill and overflow on ch2
    cpu_ch = 2; cpu_wr = 1; cpu_wdata = 16'h1111;
    tick();
    chk("ch2_out_valid_rise", out_valid, 4'b0100);
    cpu_wdata = 16'h2222; tick();
    cpu_wdata = 16'h3333; tick();
    cpu_wdata = 16'h4444; tick();
    cpu_wdata = 16'h5555; cpu_stat_rd = 1;
    tick();
    chk("ch2_status_full", cpu_status, 4'b0110);
    cpu_wr = 0;
    tick();
    chk("ch2_status_ovf", cpu_status, 4'b1110);
    cpu_stat_rd = 0;
    exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
    out_ready = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ch2_drain%0d", k), out_data[32 +: 16], exp_w[k]);
      tick();
    end
    out_ready = '0;
    chk("ch2_drained", out_valid, 4'h0);
    cpu_stat_rd = 1;
    tick();
    cpu_stat_rd = 0;
    chk("ch2_ovf_cleared", cpu_status, 4'b0010);

    // ---- TX full push + pop on ch0
    cpu_ch = 0; cpu_wr = 1;
    for (int k = 0; k < 4; k++) begin
      cpu_wdata = 16'h0A01 + 16'(k);
      tick();
    end
    cpu_wdata = 16'hBEEF; out_ready = 4'b0001;
    tick();
    cpu_wr = 0; out_ready = '0; cpu_stat_rd = 1;
    tick();
    cpu_stat_rd = 0;
    chk("ch0_full_no_ovf", cpu_status, 4'b0110);
    exp_w[0] = 16'h0A02; exp_w[1] = 16'h0A03; exp_w[2] = 16'h0A04; exp_w[3] = 16'hBEEF;
    out_ready = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ch0_drain%0d", k), out_data[0 +: 16], exp_w[k]);
      tick();
    end
    out_ready = '0;
    chk("ch0_drained", out_valid, 4'h0);

    // ---- RX latency on ch3
    cpu_ch = 3; in_data[48 +: 16] = 16'hA5A5; in_valid = 4'b1000;
    tick();
    in_valid = '0;
    chk("ch3_rvalid_idle", cpu_rvalid, 0);
    cpu_rd = 1;
    tick();
    chk("ch3_rvalid", cpu_rvalid, 1);
    chk("ch3_rdata",  cpu_rdata,  16'hA5A5);
    tick();
    cpu_rd = 0;
    chk("ch3_empty_rvalid", cpu_rvalid, 0);
    chk("ch3_empty_hold",   cpu_rdata,  16'hA5A5);

    // ---- RX full on ch0: pop on full does not free the slot that cycle
    cpu_ch = 0; in_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      in_data[0 +: 16] = 16'hD000 + 16'(k);
      tick();
    end
    chk("ch0_rx_full_ready", in_ready, 4'b1110);
    in_data[0 +: 16] = 16'hDEAD; cpu_rd = 1;
    tick();
    in_valid = '0;
    chk("ch0_rx_ready_back", in_ready, 4'hF);
    chk("ch0_rx_pop0", cpu_rdata, 16'hD000);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("ch0_rx_pop%0d", k), cpu_rdata, 16'hD000 + 16'(k));
    end
    tick();
    cpu_rd = 0;
    chk("ch0_rx_no_dead", cpu_rvalid, 0);

    // ---- sticky clear race on ch1
    cpu_ch = 1; cpu_wr = 1;
    for (int k = 0; k < 5; k++) begin
      cpu_wdata = 16'h7000 + 16'(k);
      tick();
    end
    cpu_stat_rd = 1;
    tick();
    cpu_wr = 0;
    chk("race_status1", cpu_status, 4'b1110);
    tick();
    chk("race_status2", cpu_status, 4'b1110);
    tick();
    cpu_stat_rd = 0;
    chk("race_cleared", cpu_status, 4'b0110);
    out_ready = 4'b0010;
    for (int k = 0; k < 4; k++) tick();
    out_ready = '0;
    chk("ch1_tx_drained", out_valid, 4'h0);

    // ---- RX pointer wrap on ch1 with random traffic
    cpu_ch = 1; cnt = 0; sent = 0; got = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      iv = (sent < 20) && ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 1) == 1);
      chk("wrap_in_ready", in_ready[1], (cnt < DP) ? 1 : 0);
      in_valid[1] = iv;
      in_data[16 +: 16] = 16'hC000 + 16'(sent);
      cpu_rd = rd;
      acc = iv && (cnt < DP);
      pop = rd && (cnt > 0);
      if (acc) begin
        q.push_back(16'hC000 + 16'(sent));
        sent++;
      end
      if (pop) ew = q.pop_front();
      cnt = cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
      tick();
      chk("wrap_rvalid", cpu_rvalid, pop);
      if (pop) begin
        chk("wrap_rdata", cpu_rdata, ew);
        got++;
      end
    end
    in_valid = '0; cpu_rd = 0;
    chk("wrap_words_received", got, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
Parametrised, buffered successor to the datapath's single unbuffered 16-bit ioIn/ioOut pair. It provides CHANNELS independent I/O channels. Each channel has a DEPTH-entry TX FIFO (CPU to outside) and a DEPTH-entry RX FIFO (outside to CPU), with valid/ready handshakes on the external side. It sits between the datapath's I/O instruction path and external peripherals. It adds back-pressure, buffering, and sticky overflow status, none of which the existing I/O path has.

Parameters:
DATA_W, 16, width of every data word
CHANNELS, 4, number of I/O channels (1..16)
DEPTH, 4, entries per FIFO; power of two, >= 2
CH_W, $clog2(CHANNELS) (min 1), width of channel select

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
cpu_ch  in  CH_W  channel selected for this cycle's CPU access
cpu_wr  in  1  push cpu_wdata into TX FIFO of cpu_ch
cpu_wdata  in  DATA_W  write data
cpu_rd  in  1  pop RX FIFO of cpu_ch
cpu_rdata  out  DATA_W  registered read data
cpu_rvalid  out  1  one-cycle pulse: cpu_rdata holds a popped word
cpu_stat_rd  in  1  read status of cpu_ch; clears its sticky flags
cpu_status  out  4  {ovf_sticky, tx_full, rx_empty, rx_nonempty} of cpu_ch, registered
in_data  in  CHANNELS*DATA_W  external RX data, channel i at [i*DATA_W +: DATA_W]
in_valid  in  CHANNELS  external RX valid per channel
in_ready  out  CHANNELS  RX FIFO not full per channel
out_data  out  CHANNELS*DATA_W  TX FIFO head per channel
out_valid  out  CHANNELS  TX FIFO non-empty per channel
out_ready  in  CHANNELS  external TX accept per channel

Behaviour:
- Reset low (async): all FIFOs empty (pointers and counts 0), cpu_rdata=0, cpu_rvalid=0, cpu_status=4'b0010 held in the rx_empty encoding, sticky flags 0, out_valid=0, in_ready=all-ones. After deassertion, first edge operates normally. Reset mid-transfer discards all buffered data.
- TX push: on cpu_wr with cpu_ch < CHANNELS and tx_count<DEPTH, cpu_wdata is written at wr_ptr, wr_ptr+1 (wraps mod DEPTH), count+1.
- TX push when full: word dropped, ovf_sticky[cpu_ch] set.
- TX push when full with pop in the same cycle (out_valid&out_ready on that channel): the push is accepted and the count stays DEPTH. No overflow.
- TX pop: out_valid[i] = count!=0. out_data[i] = mem[rd_ptr] combinationally. On out_valid&out_ready, rd_ptr+1, count-1.
- TX push to an empty FIFO: out_valid rises the next cycle. There is no same-cycle bypass.
- RX push: in_ready[i] = rx_count<DEPTH, registered from count, so no combinational path from in_valid. On in_valid&in_ready the word is stored. A CPU pop on a full FIFO frees the slot only from the next cycle.
- RX pop: cpu_rd with rx non-empty gives cpu_rdata=head and cpu_rvalid=1 on the next edge (latency 1). Pointer advances.
- RX pop when empty: cpu_rvalid=0 and cpu_rdata holds its previous value. No flag is set.
- cpu_rvalid is deasserted the cycle after any non-popping cycle.
- RX simultaneous external push and CPU pop on the same channel: both are performed and the count is unchanged.
- cpu_wr, cpu_rd and cpu_stat_rd may all be asserted in one cycle. All are performed on cpu_ch.
- cpu_status is sampled before that cycle's updates. The clear happens after sampling. An overflow in the same cycle as the clear leaves the sticky flag set.
- cpu_ch >= CHANNELS: writes and reads are ignored, cpu_rvalid=0, cpu_status=0.
- Channels are fully independent. No arbitration is needed because each external interface is per channel.
- Counts are $clog2(DEPTH)+1 bits wide. Pointers are $clog2(DEPTH) bits wide and wrap naturally.

Decomposition:
- Shared package io_pkg: status bit index constants (STAT_OVF=3, STAT_TXFULL=2, STAT_RXEMPTY=1, STAT_RXNE=0) and default DATA_W.
- One sub-module io_fifo (params DATA_W, DEPTH; push/pop/full/empty/count/head). It is instantiated 2*CHANNELS times via generate.
- The top contains decode, sticky flags, and the registered CPU read and status outputs.

Test Plan:
- Reset and idle: assert reset low mid-stream with 3 words buffered on ch1, then release -> out_valid=0, in_ready=4'hF, cpu_rvalid=0, cpu_status of ch1 = 4'b0010.
- TX fill/overflow: write 0x1111..0x5555 to ch2 with out_ready=0 -> out_valid[2]=1, tx_full=1 after 4 words. 5th word is dropped and ovf=1. Drain -> 0x1111,0x2222,0x3333,0x4444 in order.
- Full push+pop: TX ch0 full, same cycle cpu_wr 0xBEEF and out_ready[0]=1 -> count stays 4, no ovf, 0xBEEF emerges 4th.
- RX latency: in_data ch3=0xA5A5 valid one cycle; next cycle cpu_rd ch3 -> cpu_rvalid=1 with 0xA5A5 exactly one cycle later. A second cpu_rd returns cpu_rvalid=0.
- Sticky clear race: overflow ch1, then cpu_stat_rd and a new overflow in the same cycle -> status reads ovf=1, and the next status read still shows ovf=1.
- Pointer wrap: stream 20 words through ch1 RX with random in_valid/cpu_rd -> data order preserved. in_ready is never high when count=4.
